// File: rtl/excess3_sched.sv
// rtl/excess3_sched.sv - two-requester round-robin BCD to excess-3 converter
// A bit-serial adder adds 0011 to the granted digit, one bit per cycle, LSB first.
module excess3_sched (
    input  logic       the_clock,
    input  logic       the_reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_digit,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_digit,
    output logic       req1_ready,
    output logic       out_valid,
    output logic [3:0] out_code,
    output logic       out_id,
    output logic       out_err,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADDEND = 4'b0011;

    state_t     state;
    state_t     state_next;
    logic [3:0] digit;
    logic [2:0] sum;
    logic [1:0] cnt;
    logic       carry;
    logic       id;
    logic       last_grant;
    logic       target;
    logic       accept;
    logic       sum_bit;
    logic       carry_next;

    // A lone requester always wins; otherwise the one not served last.
    always_comb begin
        target = ~last_grant;
        if (req0_valid && !req1_valid) begin
            target = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            target = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && !target;
    assign req1_ready = (state == IDLE) && target;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign sum_bit    = digit[cnt] ^ ADDEND[cnt] ^ carry;
    assign carry_next = (digit[cnt] & ADDEND[cnt]) | (digit[cnt] & carry) | (ADDEND[cnt] & carry);

    always_ff @(posedge the_clock) begin
        if (the_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (cnt == 2'd3) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge the_clock) begin
        if (the_reset) begin
            digit      <= 4'd0;
            sum        <= 3'd0;
            cnt        <= 2'd0;
            carry      <= 1'b0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            out_valid  <= 1'b0;
            out_code   <= 4'd0;
            out_id     <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        digit      <= target ? req1_digit : req0_digit;
                        id         <= target;
                        last_grant <= target;
                        cnt        <= 2'd0;
                        carry      <= 1'b0;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the top so after three shifts sum holds bits 2..0.
                    sum   <= {sum_bit, sum[2:1]};
                    carry <= carry_next;
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        out_valid <= 1'b1;
                        out_code  <= {sum_bit, sum};
                        out_id    <= id;
                        out_err   <= (digit > 4'd9);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_excess3_sched.sv
// tb/tb_excess3_sched.sv - bench for excess3_sched
// Cycle model plus directed scenarios with literal expectations.
module tb_excess3_sched;

    logic       the_clock = 1'b0;
    logic       the_reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic [3:0] req0_digit = 4'd0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_digit = 4'd0;
    logic       req1_ready;
    logic       out_valid;
    logic [3:0] out_code;
    logic       out_id;
    logic       out_err;
    logic       out_ready = 1'b1;

    excess3_sched dut (
        .the_clock (the_clock),
        .the_reset (the_reset),
        .req0_valid(req0_valid),
        .req0_digit(req0_digit),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_digit(req1_digit),
        .req1_ready(req1_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_id    (out_id),
        .out_err   (out_err),
        .out_ready (out_ready)
    );

    always #5 the_clock = ~the_clock;

    typedef struct {int cyc; bit id;} acc_t;
    typedef struct {bit id; logic [3:0] code; bit err;} res_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    acc_t acc_q[$];
    res_t res_q[$];
    int   rise_q[$];
    bit   prev_ov = 1'b0;

    // Model: busy counts cycles since the accept; 0 = waiting, 5 = holding a result.
    int         m_busy = 0;
    bit         m_last = 1'b1;
    logic [3:0] m_digit = 4'd0;
    bit         m_rid = 1'b0;
    bit         m_ov = 1'b0;
    logic [3:0] m_code = 4'd0;
    bit         m_id = 1'b0;
    bit         m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pick();
        if (req0_valid && !req1_valid) return 1'b0;
        if (req1_valid && !req0_valid) return 1'b1;
        return ~m_last;
    endfunction

    always @(posedge the_clock) begin
        bit         t;
        logic [4:0] s;
        cyc++;
        if (!the_reset && req0_valid && req0_ready) acc_q.push_back('{cyc, 1'b0});
        if (!the_reset && req1_valid && req1_ready) acc_q.push_back('{cyc, 1'b1});
        if (!the_reset && out_valid && out_ready) res_q.push_back('{out_id, out_code, out_err});
        if (the_reset) begin
            m_busy = 0; m_last = 1'b1; m_ov = 1'b0; m_code = 4'd0; m_id = 1'b0; m_err = 1'b0;
        end else if (m_busy == 0) begin
            t = pick();
            if (t ? req1_valid : req0_valid) begin
                m_digit = t ? req1_digit : req0_digit;
                m_rid   = t;
                m_last  = t;
                m_busy  = 1;
            end
        end else if (m_busy < 4) begin
            m_busy++;
        end else if (m_busy == 4) begin
            s      = {1'b0, m_digit} + 5'd3;
            m_code = s[3:0];
            m_err  = (m_digit > 4'd9);
            m_id   = m_rid;
            m_ov   = 1'b1;
            m_busy = 5;
        end else if (out_ready) begin
            m_ov   = 1'b0;
            m_busy = 0;
        end
        #1;
        check("mdl_out_valid", out_valid, m_ov);
        check("mdl_out_code", out_code, m_code);
        check("mdl_out_id", out_id, m_id);
        check("mdl_out_err", out_err, m_err);
        check("mdl_req0_ready", req0_ready, (m_busy == 0) && !pick());
        check("mdl_req1_ready", req1_ready, (m_busy == 0) && pick());
        if (out_valid && !prev_ov) rise_q.push_back(cyc);
        prev_ov = out_valid;
    end

    // which: 0 accepts, 1 delivered results, 2 out_valid rises
    task automatic wait_for(input string name, input int which, input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge the_clock);
            if (which == 0 && acc_q.size() >= n) return;
            if (which == 1 && res_q.size() >= n) return;
            if (which == 2 && rise_q.size() >= n) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles", name, limit);
    endtask

    task automatic do_reset();
        @(negedge the_clock);
        the_reset  = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge the_clock);
        the_reset = 1'b0;
    endtask

    initial begin
        int ab;
        int rb;
        int qb;
        logic [4:0] e;

        repeat (2) @(negedge the_clock);
        the_reset = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_code", out_code, 4'b0000);
        check("rst_out_id", out_id, 1'b0);
        check("rst_req0_ready", req0_ready, 1'b1);
        check("rst_req1_ready", req1_ready, 1'b0);

        // single request, digit 5
        ab = acc_q.size(); rb = res_q.size(); qb = rise_q.size();
        req0_valid = 1'b1; req0_digit = 4'b0101;
        check("s1_req0_ready", req0_ready, 1'b1);
        wait_for("s1_accept", 0, ab + 1, 5);
        req0_valid = 1'b0;
        wait_for("s1_result", 1, rb + 1, 10);
        check("s1_code", res_q[rb].code, 4'b1000);
        check("s1_id", res_q[rb].id, 1'b0);
        check("s1_err", res_q[rb].err, 1'b0);
        check("s1_latency", rise_q[qb] - acc_q[ab].cyc, 4);

        // both requesting continuously
        do_reset();
        ab = acc_q.size(); rb = res_q.size();
        req0_valid = 1'b1; req0_digit = 4'b0010;
        req1_valid = 1'b1; req1_digit = 4'b0111;
        wait_for("s2_accepts", 0, ab + 4, 40);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_for("s2_results", 1, rb + 4, 20);
        for (int k = 0; k < 4; k++) begin
            check("s2_id", res_q[rb + k].id, k % 2);
            check("s2_code", res_q[rb + k].code, (k % 2) ? 4'b1010 : 4'b0101);
            if (k > 0) check("s2_spacing", acc_q[ab + k].cyc - acc_q[ab + k - 1].cyc, 6);
        end

        // sweep on req1
        do_reset();
        for (int d = 0; d < 16; d++) begin
            ab = acc_q.size(); rb = res_q.size();
            req1_valid = 1'b1; req1_digit = d[3:0];
            wait_for("s3_accept", 0, ab + 1, 5);
            req1_valid = 1'b0;
            wait_for("s3_result", 1, rb + 1, 10);
            e = d[4:0] + 5'd3;
            check("s3_code", res_q[rb].code, e[3:0]);
            check("s3_err", res_q[rb].err, d >= 10);
            check("s3_id", res_q[rb].id, 1'b1);
            if (d == 9)  check("s3_code_9", res_q[rb].code, 4'b1100);
            if (d == 13) check("s3_code_13", res_q[rb].code, 4'b0000);
            if (d == 15) check("s3_code_15", res_q[rb].code, 4'b0010);
        end

        // consumer stall in DONE
        ab = acc_q.size(); qb = rise_q.size();
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_digit = 4'b0100;
        wait_for("s4_accept", 0, ab + 1, 5);
        req0_valid = 1'b0;
        wait_for("s4_valid", 2, qb + 1, 10);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge the_clock);
            check("s4_hold_valid", out_valid, 1'b1);
            check("s4_hold_code", out_code, 4'b0111);
            check("s4_hold_ready", {req0_ready, req1_ready}, 2'b00);
        end
        check("s4_no_accept", acc_q.size(), ab + 1);
        out_ready = 1'b1;
        @(negedge the_clock);
        check("s4_released", out_valid, 1'b0);
        check("s4_idle_ready", req0_ready | req1_ready, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) @(negedge the_clock);

        // reset during SHIFT
        do_reset();
        ab = acc_q.size(); qb = rise_q.size();
        req0_valid = 1'b1; req0_digit = 4'b0101;
        wait_for("s5_accept", 0, ab + 1, 5);
        req0_valid = 1'b0;
        @(negedge the_clock);
        the_reset = 1'b1;
        @(negedge the_clock);
        the_reset = 1'b0;
        repeat (8) @(negedge the_clock);
        check("s5_no_valid", rise_q.size(), qb);
        check("s5_code_zero", out_code, 4'b0000);
        ab = acc_q.size(); rb = res_q.size();
        req0_valid = 1'b1; req0_digit = 4'b0011;
        req1_valid = 1'b1; req1_digit = 4'b0110;
        wait_for("s5_accept2", 0, ab + 1, 5);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("s5_grant", acc_q[ab].id, 1'b0);
        wait_for("s5_result", 1, rb + 1, 10);
        check("s5_code", res_q[rb].code, 4'b0110);

        // digit changes after accept
        do_reset();
        ab = acc_q.size(); rb = res_q.size();
        req0_valid = 1'b1; req0_digit = 4'b0001;
        wait_for("s6_accept", 0, ab + 1, 5);
        req0_valid = 1'b0; req0_digit = 4'b1111;
        wait_for("s6_result", 1, rb + 1, 10);
        check("s6_code", res_q[rb].code, 4'b0100);
        check("s6_err", res_q[rb].err, 1'b0);

        repeat (3) @(negedge the_clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
